// File: rtl/core_config_pkg.sv
// Shared configuration for the core timer: register offsets, widths, reset constants.
package core_config_pkg;

   localparam int unsigned TIMER_PRESC_W = 16;

   localparam logic [7:0] TIMER_MTIME_LO_OFF    = 8'h00;
   localparam logic [7:0] TIMER_MTIME_HI_OFF    = 8'h04;
   localparam logic [7:0] TIMER_MTIMECMP_LO_OFF = 8'h08;
   localparam logic [7:0] TIMER_MTIMECMP_HI_OFF = 8'h0C;
   localparam logic [7:0] TIMER_PRESC_OFF       = 8'h10;

   localparam logic [63:0] TIMER_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      REG_MTIME_LO,
      REG_MTIME_HI,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_PRESC,
      REG_NONE
   } timer_reg_e;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } timer_rsp_t;

   // Word-aligned address decode; PRESC only maps when the prescaler is built in.
   function automatic timer_reg_e timer_decode(input logic [31:0] a, input logic presc_en);
      timer_reg_e sel;
      sel = REG_NONE;
      if (a[1:0] == 2'b00) begin
         if (a == 32'(TIMER_MTIME_LO_OFF))         sel = REG_MTIME_LO;
         else if (a == 32'(TIMER_MTIME_HI_OFF))    sel = REG_MTIME_HI;
         else if (a == 32'(TIMER_MTIMECMP_LO_OFF)) sel = REG_CMP_LO;
         else if (a == 32'(TIMER_MTIMECMP_HI_OFF)) sel = REG_CMP_HI;
         else if (presc_en && (a == 32'(TIMER_PRESC_OFF))) sel = REG_PRESC;
      end
      return sel;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides tick_en pulses: one step every (presc+1) ticks; clr restarts the count.
import core_config_pkg::*;

module timer_prescaler #(
   parameter int unsigned PRESC_W = TIMER_PRESC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_en,
   input  logic [PRESC_W-1:0] presc,
   input  logic               clr,
   output logic               step
);

   logic [PRESC_W-1:0] cnt_q;
   logic               hit_c;

   assign hit_c = (cnt_q == presc);
   assign step  = tick_en & hit_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (tick_en) begin
         cnt_q <= hit_c ? '0 : cnt_q + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/core_timer.sv
// Machine timer: 64-bit mtime/mtimecmp, level interrupt, single-cycle register bus.
// Optional prescaler at 0x10 is compiled in with CORE_TIMER_PRESCALER_EN.
import core_config_pkg::*;

module core_timer #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned PRESC_W = TIMER_PRESC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_en,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ack,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              timer_irq
);

   if (PRESC_W == 0 || PRESC_W > 32) begin : g_bad_presc_w
      $error("PRESC_W must be in 1..32");
   end

`ifdef CORE_TIMER_PRESCALER_EN
   localparam logic PRESC_EN = 1'b1;
`else
   localparam logic PRESC_EN = 1'b0;
`endif

   logic [63:0] mtime_q;
   logic [63:0] mtimecmp_q;
   logic [31:0] hi_shadow_q;

   timer_reg_e sel_c;
   logic       wr_c;
   logic       rd_c;
   logic       step_c;
   timer_rsp_t rsp_c;

   always_comb begin
      sel_c = timer_decode(32'(addr), PRESC_EN);
      wr_c  = req &  we & (sel_c != REG_NONE);
      rd_c  = req & ~we & (sel_c != REG_NONE);
   end

`ifdef CORE_TIMER_PRESCALER_EN
   logic [PRESC_W-1:0] presc_q;
   logic               presc_wr_c;

   assign presc_wr_c = wr_c & (sel_c == REG_PRESC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          presc_q <= '0;
      else if (presc_wr_c) presc_q <= wdata[PRESC_W-1:0];
   end

   timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_en (tick_en),
      .presc   (presc_q),
      .clr     (presc_wr_c),
      .step    (step_c)
   );
`else
   assign step_c = tick_en;
`endif

   // A bus write to either half overrides the increment for that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q <= '0;
      end else if (wr_c && sel_c == REG_MTIME_LO) begin
         mtime_q[31:0] <= wdata;
      end else if (wr_c && sel_c == REG_MTIME_HI) begin
         mtime_q[63:32] <= wdata;
      end else if (step_c) begin
         mtime_q <= mtime_q + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtimecmp_q <= TIMER_MTIMECMP_RST;
      end else if (wr_c && sel_c == REG_CMP_LO) begin
         mtimecmp_q[31:0] <= wdata;
      end else if (wr_c && sel_c == REG_CMP_HI) begin
         mtimecmp_q[63:32] <= wdata;
      end
   end

   // Low-word read freezes the high word so a LO-then-HI pair is coherent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            hi_shadow_q <= '0;
      else if (rd_c && sel_c == REG_MTIME_LO) hi_shadow_q <= mtime_q[63:32];
   end

   always_comb begin
      rsp_c       = '0;
      rsp_c.err   = req & (sel_c == REG_NONE);
      if (rd_c) begin
         case (sel_c)
            REG_MTIME_LO: rsp_c.rdata = mtime_q[31:0];
            REG_MTIME_HI: rsp_c.rdata = hi_shadow_q;
            REG_CMP_LO:   rsp_c.rdata = mtimecmp_q[31:0];
            REG_CMP_HI:   rsp_c.rdata = mtimecmp_q[63:32];
`ifdef CORE_TIMER_PRESCALER_EN
            REG_PRESC:    rsp_c.rdata = 32'(presc_q);
`endif
            default:      rsp_c.rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack       <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         timer_irq <= 1'b0;
      end else begin
         ack       <= req;
         err       <= rsp_c.err;
         rdata     <= rsp_c.rdata;
         timer_irq <= (mtime_q >= mtimecmp_q);
      end
   end

endmodule

// File: tb/tb_core_timer.sv
// Directed bench for core_timer: vector table for bus decode plus hand-written timing sequences.
module tb_core_timer;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        tick_en = 1'b0;
   logic        req     = 1'b0;
   logic        we      = 1'b0;
   logic [4:0]  addr    = '0;
   logic [31:0] wdata   = '0;
   logic        ack;
   logic        err;
   logic [31:0] rdata;
   logic        timer_irq;

   int checks = 0;
   int errors = 0;

   core_timer #(.ADDR_W(5), .PRESC_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_en   (tick_en),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .err       (err),
      .rdata     (rdata),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; issues one request and returns at the next negedge with the response.
   task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      check("ack", 32'(ack), 32'd1);
      rd = rdata;
      e  = err;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic        e;
      bus(1'b1, a, d, rd, e);
      check("wr_err", 32'(e), 32'd0);
   endtask

   task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic        e;
      bus(1'b0, a, 32'd0, rd, e);
      check({name, "_err"}, 32'(e), 32'd0);
      check(name, rd, exp);
   endtask

   task automatic tick_once();
      tick_en = 1'b1;
      @(negedge clk);
      tick_en = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      logic        presc_err;

`ifdef CORE_TIMER_PRESCALER_EN
      presc_err = 1'b0;
`else
      presc_err = 1'b1;
`endif
      vecs[0]  = '{1'b0, 5'h00, 32'h0,      1'b0,      32'd10};
      vecs[1]  = '{1'b0, 5'h04, 32'h0,      1'b0,      32'd0};
      vecs[2]  = '{1'b0, 5'h08, 32'h0,      1'b0,      32'hFFFF_FFFF};
      vecs[3]  = '{1'b0, 5'h0C, 32'h0,      1'b0,      32'hFFFF_FFFF};
      vecs[4]  = '{1'b1, 5'h00, 32'h1234,   1'b0,      32'd0};
      vecs[5]  = '{1'b0, 5'h00, 32'h0,      1'b0,      32'h1234};
      vecs[6]  = '{1'b0, 5'h06, 32'h0,      1'b1,      32'd0};
      vecs[7]  = '{1'b1, 5'h06, 32'hDEAD,   1'b1,      32'd0};
      vecs[8]  = '{1'b0, 5'h14, 32'h0,      1'b1,      32'd0};
      vecs[9]  = '{1'b1, 5'h14, 32'hBEEF,   1'b1,      32'd0};
      vecs[10] = '{1'b1, 5'h02, 32'h5555,   1'b1,      32'd0};
      vecs[11] = '{1'b0, 5'h10, 32'h0,      presc_err, 32'd0};
      vecs[12] = '{1'b1, 5'h10, 32'h0,      presc_err, 32'd0};
      vecs[13] = '{1'b0, 5'h00, 32'h0,      1'b0,      32'h1234};
      vecs[14] = '{1'b0, 5'h04, 32'h0,      1'b0,      32'd0};
      vecs[15] = '{1'b0, 5'h0C, 32'h0,      1'b0,      32'hFFFF_FFFF};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_irq", 32'(timer_irq), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ten ticks from reset, interrupt must stay low
      tick_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("irq_low_%0d", i), 32'(timer_irq), 32'd0);
      end
      tick_en = 1'b0;

      for (int i = 0; i < 16; i++) begin
         bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e);
         check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end

      // Interrupt rises one cycle after mtime reaches 5
      wr(5'h00, 32'd0);
      wr(5'h0C, 32'd0);
      wr(5'h08, 32'd5);
      tick_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check($sformatf("irq_edge%0d", i), 32'(timer_irq), (i >= 6) ? 32'd1 : 32'd0);
      end
      wr(5'h08, 32'd100);
      check("irq_hold", 32'(timer_irq), 32'd1);
      @(negedge clk);
      check("irq_drop", 32'(timer_irq), 32'd0);
      tick_en = 1'b0;
      rd_chk("mtime_after_irq", 5'h00, 32'd10);

      // Carry from low into high half
      wr(5'h04, 32'd0);
      wr(5'h00, 32'hFFFF_FFFF);
      tick_once();
      rd_chk("carry_lo", 5'h00, 32'd0);
      rd_chk("carry_hi", 5'h04, 32'd1);
      check("irq_big", 32'(timer_irq), 32'd1);

      // Full 64-bit wrap
      wr(5'h04, 32'hFFFF_FFFF);
      wr(5'h00, 32'hFFFF_FFFF);
      tick_once();
      rd_chk("wrap_lo", 5'h00, 32'd0);
      rd_chk("wrap_hi", 5'h04, 32'd0);
      @(negedge clk);
      check("irq_wrap", 32'(timer_irq), 32'd0);

      // High read comes from the shadow captured by the low read
      wr(5'h00, 32'hFFFF_FFFF);
      wr(5'h04, 32'd3);
      rd_chk("shadow_lo", 5'h00, 32'hFFFF_FFFF);
      tick_once();
      rd_chk("shadow_hi", 5'h04, 32'd3);
      rd_chk("live_lo", 5'h00, 32'd0);
      rd_chk("live_hi", 5'h04, 32'd4);

      // Write beats a simultaneous tick; counting resumes afterwards
      tick_en = 1'b1;
      wr(5'h00, 32'h1234);
      rd_chk("write_wins", 5'h00, 32'h1234);
      tick_en = 1'b0;
      rd_chk("resume", 5'h00, 32'h1235);
      check("irq_pre_rst", 32'(timer_irq), 32'd1);

      // Reset in the middle of a transaction drops the ack
      req = 1'b1; we = 1'b0; addr = 5'h00;
      @(posedge clk);
      #1;
      check("ack_before_rst", 32'(ack), 32'd1);
      rst_n = 1'b0;
      req = 1'b0;
      #1;
      check("ack_rst", 32'(ack), 32'd0);
      check("irq_rst", 32'(timer_irq), 32'd0);
      check("rdata_rst", rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk("cmp_lo_rst", 5'h08, 32'hFFFF_FFFF);
      rd_chk("mtime_lo_rst", 5'h00, 32'd0);
      rd_chk("mtime_hi_rst", 5'h04, 32'd0);

`ifdef CORE_TIMER_PRESCALER_EN
      // Divide by four: twelve ticks give three steps
      wr(5'h10, 32'd3);
      rd_chk("presc_rd", 5'h10, 32'd3);
      wr(5'h00, 32'd0);
      tick_en = 1'b1;
      repeat (12) @(negedge clk);
      tick_en = 1'b0;
      rd_chk("presc_mtime", 5'h00, 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_timer.md
# core_timer

Machine-level timer for the RV32 core: a 64-bit `mtime` counter advanced by the core clock-enable pulse, a 64-bit `mtimecmp` compare register, and a level timer interrupt. It sits directly downstream of the clock-enable generator; that block's `clk_en` drives `tick_en` here. A single-cycle register bus from the core's load/store path accesses the timer.

## Interface
Parameters:
- `ADDR_W`, default 5: register-bus address width, byte addressing.
- `PRESC_W`, default 16: prescaler register width. Used only when the prescaler is compiled in.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `tick_en`, in, 1: time-base enable pulse from the clock-enable generator.
- `req`, in, 1: bus request, one-cycle pulse.
- `we`, in, 1: 1 = write, 0 = read. Sampled with `req`.
- `addr`, in, ADDR_W: byte address. Sampled with `req`.
- `wdata`, in, 32: write data.
- `ack`, out, 1: transaction complete, one-cycle pulse.
- `err`, out, 1: access error; valid with `ack`.
- `rdata`, out, 32: read data; valid with `ack`.
- `timer_irq`, out, 1: machine timer interrupt, level.

## Operation
Register map (32-bit word access only):
- 0x00: `MTIME_LO`.
- 0x04: `MTIME_HI`.
- 0x08: `MTIMECMP_LO`.
- 0x0C: `MTIMECMP_HI`.
- 0x10: `PRESC` (prescaler builds only).

Counting:
- `mtime` advances by 1 per *time step*.
- A time step is every cycle with `tick_en`=1, or every (PRESC+1)th such cycle when the prescaler is compiled in.
- `mtime` is 64-bit unsigned and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 silently.
- A bus write to `MTIME_LO` or `MTIME_HI` in the same cycle as a time step wins: the written half takes `wdata`, the other half holds, and there is no increment that cycle.
- A write updates exactly one 32-bit half. No carry is propagated by a write.

Coherent 64-bit read:
- Reading `MTIME_LO` returns the low word and snapshots the current high word into `hi_shadow`.
- Reading `MTIME_HI` returns `hi_shadow`, not the live high word.
- Software reads LO then HI.

Interrupt:
- `timer_irq` is the registered value of (`mtime` >= `mtimecmp`), unsigned 64-bit compare.
- It stays asserted until `mtimecmp` is raised or `mtime` is rewritten below it.

Errors:
- `err`=1 with `ack` when `addr[1:0]`≠0 or the address is unmapped.
- On error: reads return `rdata`=0 and writes have no effect.

## Timing
- Reset values:
  - `ack`=0, `err`=0, `rdata`=0, `timer_irq`=0.
  - `mtime`=0, `hi_shadow`=0, `PRESC`=0, prescaler count=0.
  - `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, so no interrupt out of reset.
- Bus latency: `req` in cycle N gives `ack` in cycle N+1 with `rdata`/`err` valid, for reads and writes alike.
- `req` is legal every cycle (back-to-back); there are no wait states.
- Write effects are visible to a read issued in the next cycle.
- Read data is the register value at cycle N, before any cycle-N update.
- `timer_irq` lags any `mtime`/`mtimecmp` change by exactly 1 cycle.
- `tick_en` held high permanently gives one increment per cycle (PRESC=0).
- Reset mid-transaction: a pending `ack` is dropped and all state returns to reset values asynchronously.

## Configuration
Macro: `CORE_TIMER_PRESCALER_EN`.

When defined:
- `PRESC` (PRESC_W bits, zero-extended on read) exists at 0x10.
- A prescaler counter counts `tick_en` pulses. When count == PRESC it clears to 0 and issues a time step; otherwise it increments.
- Writing `PRESC` clears the prescaler count in the same cycle.

When undefined:
- Every `tick_en` is a time step.
- Address 0x10 returns `err`=1.
- No prescaler logic is synthesised.

## Structure
- In `core_config_pkg`: register offsets (`TIMER_MTIME_LO_OFF` … `TIMER_PRESC_OFF`), `TIMER_PRESC_W`, and the `mtimecmp` reset constant.
- One sub-module, `timer_prescaler`: inputs `tick_en`, `presc`, `clr`; output `step`. It is instantiated only under `CORE_TIMER_PRESCALER_EN`.
- Bus decode, `mtime`/`mtimecmp`/`hi_shadow` and the comparator stay in `core_timer`.

## Test plan
- Reset, then `tick_en` high for 10 cycles.
  - Expect `mtime`=10.
  - Expect `timer_irq`=0 throughout.
  - Expect `mtimecmp` to read 0xFFFF_FFFF on both halves.
- Write `MTIMECMP_HI`=0 and `MTIMECMP_LO`=5 with `tick_en` high.
  - `timer_irq` rises 1 cycle after `mtime` reaches 5.
  - Writing `MTIMECMP_LO`=100 drops it 1 cycle later.
- Write `MTIME_HI`=0, `MTIME_LO`=0xFFFF_FFFF, then tick once.
  - `MTIME_LO` reads 0 and `MTIME_HI` reads 1.
  - Set both halves to all-ones and tick: `mtime` wraps to 0.
- Read `MTIME_LO` with lo=0xFFFF_FFFF, hi=3, then tick, then read `MTIME_HI`.
  - The HI read returns 3, from the shadow, while the live high word is 4.
- Write `MTIME_LO`=0x1234 in a cycle where `tick_en`=1.
  - Next read returns 0x1234; the write wins and there is no increment.
- Access `addr`=0x06 and `addr`=0x14.
  - Both give `ack` with `err`=1 and `rdata`=0, and no state change.
- With `CORE_TIMER_PRESCALER_EN`, write PRESC=3 and apply 12 `tick_en` pulses.
  - Expect `mtime`+=3.
- Without `CORE_TIMER_PRESCALER_EN`, access 0x10.
  - Expect `err`=1.
